// File: rtl/lms_pkg.sv
// Shared defaults and FSM state type for the LMS error-calculation stage.
package lms_pkg;

  localparam int DW_DEF     = 32;
  localparam int N_TAPS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    ERR  = 2'd2,
    UPD  = 2'd3
  } lms_state_t;

endpackage : lms_pkg

// File: rtl/lms_err_cal_if.sv
// Sample handshake plus the weight/tap/error bus shared with the weight-update stage.
interface lms_err_cal_if
  import lms_pkg::*;
#(
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int DW     = DW_DEF
);

  logic                 sample_valid;
  logic                 sample_ready;
  logic [DW-1:0]        x_in;
  logic [DW-1:0]        d_in;
  logic [N_TAPS*DW-1:0] weight_bus;
  logic [N_TAPS*DW-1:0] reff_bus;
  logic [DW-1:0]        y_out;
  logic [DW-1:0]        e;
  logic                 weight_cal_state;

  // master: sample source / weight-update side; slave: lms_err_cal
  modport master (
    output sample_valid, x_in, d_in, weight_bus,
    input  sample_ready, reff_bus, y_out, e, weight_cal_state
  );

  modport slave (
    input  sample_valid, x_in, d_in, weight_bus,
    output sample_ready, reff_bus, y_out, e, weight_cal_state
  );

endinterface : lms_err_cal_if

// File: rtl/lms_tap_line.sv
// Reference-sample delay line; reff[0] (lowest DW bits) holds the newest sample.
module lms_tap_line
  import lms_pkg::*;
#(
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 shift_en,
  input  logic [DW-1:0]        x_in,
  output logic [N_TAPS*DW-1:0] reff_bus
);

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      reff_bus <= '0;
    end else if (shift_en) begin
      reff_bus <= {reff_bus[(N_TAPS-1)*DW-1:0], x_in};
    end
  end

endmodule : lms_tap_line

// File: rtl/lms_err_cal.sv
// Filter output via one shared multiplier (one tap per cycle) and scaled error
// e = (d - y) >>> MU_SHIFT, with a one-cycle strobe to the weight-update stage.
module lms_err_cal
  import lms_pkg::*;
#(
  parameter int N_TAPS   = N_TAPS_DEF,
  parameter int DW       = DW_DEF,
  parameter int MU_SHIFT = 0
) (
  input  logic          clk,
  input  logic          rstn,
  lms_err_cal_if.slave  bus
);

  localparam int KW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

  lms_state_t           state, next_state;
  logic [KW-1:0]        k;
  logic                 ready;
  logic                 accept;
  logic                 mac_last;
  logic [DW-1:0]        acc;
  logic [DW-1:0]        d_q;
  logic [DW-1:0]        w_sel;
  logic [DW-1:0]        r_sel;
  logic [DW-1:0]        prod;
  logic [DW-1:0]        diff;
  logic signed [DW-1:0] e_shift;
  logic [N_TAPS*DW-1:0] reff;
  logic [DW-1:0]        y_q;
  logic [DW-1:0]        e_q;
  logic                 upd_strobe;

  lms_tap_line #(
    .N_TAPS (N_TAPS),
    .DW     (DW)
  ) u_tap_line (
    .clk      (clk),
    .rstn     (rstn),
    .shift_en (accept),
    .x_in     (bus.x_in),
    .reff_bus (reff)
  );

  assign bus.sample_ready     = ready;
  assign bus.reff_bus         = reff;
  assign bus.y_out            = y_q;
  assign bus.e                = e_q;
  assign bus.weight_cal_state = upd_strobe;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    mac_last   = (k == KW'(N_TAPS - 1));
    case (state)
      IDLE: begin
        accept = ready && bus.sample_valid;
        if (accept) next_state = MAC;
      end
      MAC:     if (mac_last) next_state = ERR;
      ERR:     next_state = UPD;
      UPD:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Products and sums are kept to DW bits: the low half of a two's-complement
  // product is sign-agnostic, and everything wraps modulo 2^DW.
  always_comb begin
    w_sel   = bus.weight_bus[int'(k)*DW +: DW];
    r_sel   = reff[int'(k)*DW +: DW];
    prod    = w_sel * r_sel;
    diff    = d_q - acc;
    e_shift = $signed(diff) >>> MU_SHIFT;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ready      <= 1'b0;
      k          <= '0;
      acc        <= '0;
      d_q        <= '0;
      y_q        <= '0;
      e_q        <= '0;
      upd_strobe <= 1'b0;
    end else begin
      // Registered so the block stays not-ready during reset and for the
      // first edge after it is released.
      ready      <= (next_state == IDLE);
      upd_strobe <= (state == ERR);
      case (state)
        IDLE: begin
          if (accept) begin
            d_q <= bus.d_in;
            acc <= '0;
            k   <= '0;
          end
        end
        MAC: begin
          acc <= acc + prod;
          k   <= mac_last ? '0 : k + KW'(1);
        end
        ERR: begin
          y_q <= acc;
          e_q <= e_shift;
        end
        default: ;
      endcase
    end
  end

endmodule : lms_err_cal
